// File: rtl/pwm_pkg.sv
// pwm_pkg: shared FSM encoding and duty/divider sizing for the PWM capture block.
package pwm_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HIGH = 2'd1,
        LOW  = 2'd2
    } state_t;

    localparam int DUTY_W    = 8;
    localparam int DIV_ITERS = 8;
endpackage

// File: rtl/pwm_duty_div.sv
// pwm_duty_div: sequential restoring divider, one quotient bit per cycle.
// The upper CNT_W bits of dividend must be below divisor so the quotient fits DUTY_W bits.
import pwm_pkg::*;

module pwm_duty_div #(
    parameter int CNT_W = 16
) (
    input  logic                    clk_in,
    input  logic                    rst,
    input  logic                    start,
    input  logic [CNT_W+DUTY_W-1:0] dividend,
    input  logic [CNT_W-1:0]        divisor,
    output logic                    busy,
    output logic                    done,
    output logic [DUTY_W-1:0]       quotient,
    output logic [CNT_W-1:0]        divisor_q
);
    localparam int ITER_W = $clog2(DIV_ITERS);

    logic [CNT_W-1:0]  rem;
    logic [DUTY_W-1:0] low;
    logic [ITER_W-1:0] iter;
    logic [CNT_W:0]    trial, diff;
    logic              ge;

    assign trial = {rem, low[DUTY_W-1]};
    assign diff  = trial - {1'b0, divisor_q};
    assign ge    = trial >= {1'b0, divisor_q};

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            rem       <= '0;
            low       <= '0;
            iter      <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            quotient  <= '0;
            divisor_q <= '0;
        end else begin
            done <= 1'b0;
            if (start) begin
                rem       <= dividend[CNT_W+DUTY_W-1:DUTY_W];
                low       <= dividend[DUTY_W-1:0];
                divisor_q <= divisor;
                quotient  <= '0;
                iter      <= '0;
                busy      <= 1'b1;
            end else if (busy) begin
                // Remainder stays below the divisor, so CNT_W bits hold it after each step.
                rem      <= ge ? diff[CNT_W-1:0] : trial[CNT_W-1:0];
                low      <= {low[DUTY_W-2:0], 1'b0};
                quotient <= {quotient[DUTY_W-2:0], ge};
                iter     <= iter + 1'b1;
                if (iter == ITER_W'(DIV_ITERS - 1)) begin
                    busy <= 1'b0;
                    done <= 1'b1;
                end
            end
        end
    end
endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures period and duty of an asynchronous PWM input, reported over valid/ready.
// Define PWM_CAPTURE_FILTER_EN for a 3-sample majority glitch filter (adds one cycle of latency).
import pwm_pkg::*;

module pwm_capture #(
    parameter int CNT_W   = 16,
    parameter int TIMEOUT = 65535
) (
    input  logic              clk_in,
    input  logic              rst,
    input  logic              pwm_in,
    input  logic              ready,
    input  logic              overrun_clr,
    output logic              valid,
    output logic [DUTY_W-1:0] duty,
    output logic [CNT_W-1:0]  period,
    output logic              stuck,
    output logic              overrun
);
    logic sync1, sync2, lvl, lvl_d, rise, fall;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
            lvl_d <= 1'b0;
        end else begin
            sync1 <= pwm_in;
            sync2 <= sync1;
            lvl_d <= lvl;
        end
    end

`ifdef PWM_CAPTURE_FILTER_EN
    logic [1:0] hist;

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) hist <= '0;
        else     hist <= {hist[0], sync2};
    end

    // Any two of the last three samples decide the level, so a single-cycle pulse never gets through.
    assign lvl = (sync2 & hist[0]) | (sync2 & hist[1]) | (hist[0] & hist[1]);
`else
    assign lvl = sync2;
`endif

    assign rise = lvl & ~lvl_d;
    assign fall = ~lvl & lvl_d;

    state_t            state, state_nx;
    logic [CNT_W-1:0]  cnt, hi;
    logic              timeout, edge_evt, snap, stuck_evt, div_start;
    logic              div_busy, div_done;
    logic [DUTY_W-1:0] div_q;
    logic [CNT_W-1:0]  div_per;

    assign timeout = (cnt == CNT_W'(TIMEOUT));

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (rise) state_nx = HIGH;
            HIGH:    if (fall) state_nx = LOW;  else if (timeout) state_nx = IDLE;
            LOW:     if (rise) state_nx = HIGH; else if (timeout) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        edge_evt  = (state == HIGH) ? fall : rise;
        snap      = (state == LOW) && rise;
        stuck_evt = timeout && !edge_evt;
        div_start = snap && !div_busy && !div_done;
    end

    // A timeout restarts the count at 1 so a static line reports exactly every TIMEOUT cycles.
    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            cnt <= '0;
            hi  <= '0;
        end else if (edge_evt && state == HIGH) begin
            hi  <= cnt;
            cnt <= cnt + 1'b1;
        end else if (edge_evt || stuck_evt) begin
            cnt <= CNT_W'(1);
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    pwm_duty_div #(.CNT_W(CNT_W)) u_div (
        .clk_in    (clk_in),
        .rst       (rst),
        .start     (div_start),
        .dividend  ({hi, {DUTY_W{1'b0}}}),
        .divisor   (cnt),
        .busy      (div_busy),
        .done      (div_done),
        .quotient  (div_q),
        .divisor_q (div_per)
    );

    logic hold, new_res, drop;

    assign hold    = valid && !ready;
    assign new_res = div_done || stuck_evt;
    assign drop    = (new_res && hold) || (snap && (div_busy || div_done)) || (div_done && stuck_evt);

    always_ff @(posedge clk_in or posedge rst) begin
        if (rst) begin
            valid   <= 1'b0;
            duty    <= '0;
            period  <= '0;
            stuck   <= 1'b0;
            overrun <= 1'b0;
        end else begin
            overrun <= (overrun && !overrun_clr) || drop;
            if (new_res && !hold) begin
                valid <= 1'b1;
                if (div_done) begin
                    duty   <= div_q;
                    period <= div_per;
                    stuck  <= 1'b0;
                end else begin
                    duty   <= {DUTY_W{lvl}};
                    period <= '0;
                    stuck  <= 1'b1;
                end
            end else if (valid && ready) begin
                valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: directed vector table plus hand-written corner sequences for pwm_capture.
module tb_pwm_capture;
    localparam int TO = 400;
`ifdef PWM_CAPTURE_FILTER_EN
    localparam int EXP_LAT = 12;
    localparam int G_DUTY  = 64;
    localparam int G_PER   = 100;
`else
    localparam int EXP_LAT = 11;
    localparam int G_DUTY  = 116;
    localparam int G_PER   = 55;
`endif

    logic        clk_in = 1'b0;
    logic        rst = 1'b1;
    logic        pwm_in = 1'b0;
    logic        ready = 1'b1;
    logic        overrun_clr = 1'b0;
    logic        valid, stuck, overrun;
    logic [7:0]  duty;
    logic [15:0] period;

    logic        pwm_big = 1'b0;
    logic        ready_big = 1'b1;
    logic        clr_big = 1'b0;
    logic        valid_big, stuck_big, overrun_big;
    logic [7:0]  duty_big;
    logic [15:0] period_big;

    pwm_capture #(.CNT_W(16), .TIMEOUT(TO)) dut (
        .clk_in(clk_in), .rst(rst), .pwm_in(pwm_in), .ready(ready), .overrun_clr(overrun_clr),
        .valid(valid), .duty(duty), .period(period), .stuck(stuck), .overrun(overrun)
    );

    pwm_capture dut_big (
        .clk_in(clk_in), .rst(rst), .pwm_in(pwm_big), .ready(ready_big), .overrun_clr(clr_big),
        .valid(valid_big), .duty(duty_big), .period(period_big), .stuck(stuck_big), .overrun(overrun_big)
    );

    always #5 clk_in = ~clk_in;

    int cyc = 0;
    always @(posedge clk_in) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    typedef struct { logic lvl; int cyc; } seg_t;
    seg_t segs[$];

    task automatic seg(input logic l, input int c);
        segs.push_back('{l, c});
    endtask

    task automatic play();
        foreach (segs[i]) begin
            @(posedge clk_in);
            #1 pwm_in = segs[i].lvl;
            repeat (segs[i].cyc - 1) @(posedge clk_in);
        end
        segs.delete();
    endtask

    int r_duty[$];
    int r_per[$];
    int r_stk[$];
    int r_time[$];

    task automatic clear_results();
        r_duty.delete(); r_per.delete(); r_stk.delete(); r_time.delete();
    endtask

    task automatic collect(input int n, input int budget);
        int got = 0;
        for (int c = 0; c < budget && got < n; c++) begin
            @(negedge clk_in);
            if (valid && ready) begin
                r_duty.push_back(int'(duty));
                r_per.push_back(int'(period));
                r_stk.push_back(int'(stuck));
                r_time.push_back(cyc);
                got++;
            end
        end
    endtask

    task automatic do_reset();
        pwm_in = 1'b0;
        overrun_clr = 1'b0;
        rst = 1'b1;
        repeat (2) @(posedge clk_in);
        #1 rst = 1'b0;
    endtask

    typedef struct { int hi; int per; int duty; int period; } vec_t;
    vec_t vecs[6];

    initial begin
        int  lat;
        bit  found;
        bit  saw_valid;

        vecs[0] = '{25, 100, 64, 100};
        vecs[1] = '{50, 100, 128, 100};
        vecs[2] = '{3, 200, 3, 200};
        vecs[3] = '{197, 200, 252, 200};
        vecs[4] = '{10, 30, 85, 30};
        vecs[5] = '{7, 13, 137, 13};

        repeat (3) @(posedge clk_in);
        #1 rst = 1'b0;
        @(negedge clk_in);
        check("reset_valid", valid, 0);
        check("reset_duty", duty, 0);
        check("reset_period", period, 0);
        check("reset_stuck", stuck, 0);
        check("reset_overrun", overrun, 0);

        // Generator-style long period on the full-width instance.
        repeat (10) @(posedge clk_in);
        #1 pwm_big = 1'b1;
        repeat (24064) @(posedge clk_in);
        #1 pwm_big = 1'b0;
        repeat (24064) @(posedge clk_in);
        #1 pwm_big = 1'b1;
        found = 1'b0;
        for (int c = 0; c < 40 && !found; c++) begin
            @(negedge clk_in);
            if (valid_big) found = 1'b1;
        end
        check("big_valid", found, 1);
        check("big_duty", duty_big, 128);
        check("big_period", period_big, 48128);
        check("big_stuck", stuck_big, 0);
        #1 pwm_big = 1'b0;

        foreach (vecs[v]) begin
            do_reset();
            ready = 1'b1;
            clear_results();
            seg(1'b0, 10);
            repeat (3) begin
                seg(1'b1, vecs[v].hi);
                seg(1'b0, vecs[v].per - vecs[v].hi);
            end
            seg(1'b1, 5);
            seg(1'b0, 20);
            fork
                play();
                collect(3, 4 * vecs[v].per + 100);
            join
            check($sformatf("vec%0d_count", v), r_duty.size(), 3);
            for (int k = 0; k < r_duty.size(); k++) begin
                check($sformatf("vec%0d_duty%0d", v, k), r_duty[k], vecs[v].duty);
                check($sformatf("vec%0d_period%0d", v, k), r_per[k], vecs[v].period);
                check($sformatf("vec%0d_stuck%0d", v, k), r_stk[k], 0);
            end
        end

        // Latency from the first synchroniser flop capturing a rise to valid.
        do_reset();
        seg(1'b0, 5);
        seg(1'b1, 20);
        seg(1'b0, 20);
        play();
        @(posedge clk_in);
        #1 pwm_in = 1'b1;
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk_in);
            #1;
            if (valid) begin
                lat = k - 1;
                break;
            end
        end
        check("latency", lat, EXP_LAT);
        check("latency_duty", duty, 128);
        check("latency_period", period, 40);
        pwm_in = 1'b0;

        // Static low line reports twice, TO apart; static high reports duty 255.
        do_reset();
        clear_results();
        collect(2, 2 * TO + 50);
        check("stuck_lo_count", r_duty.size(), 2);
        if (r_duty.size() == 2) begin
            check("stuck_lo_duty0", r_duty[0], 0);
            check("stuck_lo_period0", r_per[0], 0);
            check("stuck_lo_flag0", r_stk[0], 1);
            check("stuck_lo_duty1", r_duty[1], 0);
            check("stuck_lo_flag1", r_stk[1], 1);
            check("stuck_lo_interval", r_time[1] - r_time[0], TO);
        end
        #1 pwm_in = 1'b1;
        clear_results();
        collect(1, TO + 50);
        check("stuck_hi_count", r_duty.size(), 1);
        if (r_duty.size() == 1) begin
            check("stuck_hi_duty", r_duty[0], 255);
            check("stuck_hi_period", r_per[0], 0);
            check("stuck_hi_flag", r_stk[0], 1);
        end

        // Consumer stalled across three periods: first result held, later ones dropped.
        do_reset();
        ready = 1'b0;
        seg(1'b0, 5);
        seg(1'b1, 25); seg(1'b0, 75);
        seg(1'b1, 50); seg(1'b0, 50);
        seg(1'b1, 50); seg(1'b0, 50);
        seg(1'b1, 5);  seg(1'b0, 30);
        play();
        @(negedge clk_in);
        check("ovr_valid_held", valid, 1);
        check("ovr_duty_held", duty, 64);
        check("ovr_period_held", period, 100);
        check("ovr_flag", overrun, 1);
        @(posedge clk_in);
        #1 overrun_clr = 1'b1;
        @(posedge clk_in);
        #1 overrun_clr = 1'b0;
        check("ovr_cleared", overrun, 0);
        check("ovr_valid_after_clr", valid, 1);
        ready = 1'b1;
        @(posedge clk_in);
        #1;
        check("ovr_accept_clears_valid", valid, 0);

        // Reset in the middle of a divide aborts the result.
        do_reset();
        ready = 1'b1;
        seg(1'b0, 5);
        seg(1'b1, 25);
        seg(1'b0, 75);
        play();
        @(posedge clk_in);
        #1 pwm_in = 1'b1;
        repeat (6) @(posedge clk_in);
        #1 rst = 1'b1;
        pwm_in = 1'b0;
        @(posedge clk_in);
        #1 rst = 1'b0;
        saw_valid = 1'b0;
        repeat (30) begin
            @(negedge clk_in);
            if (valid) saw_valid = 1'b1;
        end
        check("abort_no_valid", saw_valid, 0);
        check("abort_period", period, 0);
        check("abort_duty", duty, 0);
        check("abort_overrun", overrun, 0);
        clear_results();
        seg(1'b0, 10);
        seg(1'b1, 25);
        seg(1'b0, 75);
        seg(1'b1, 5);
        seg(1'b0, 30);
        fork
            play();
            collect(1, 300);
        join
        check("abort_recover_count", r_duty.size(), 1);
        if (r_duty.size() == 1) begin
            check("abort_recover_duty", r_duty[0], 64);
            check("abort_recover_period", r_per[0], 100);
        end

        // Single-cycle glitch inside the low phase.
        do_reset();
        clear_results();
        seg(1'b0, 5);
        seg(1'b1, 25); seg(1'b0, 30); seg(1'b1, 1); seg(1'b0, 44);
        seg(1'b1, 25); seg(1'b0, 75);
        seg(1'b1, 5);  seg(1'b0, 30);
        fork
            play();
            collect(1, 400);
        join
        check("glitch_count", r_duty.size(), 1);
        if (r_duty.size() == 1) begin
            check("glitch_duty", r_duty[0], G_DUTY);
            check("glitch_period", r_per[0], G_PER);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end
endmodule
